// File: rtl/sprom_playback_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : sprom_playback_ctrl_if
//  Brief    : ROM read port plus AXI4-Stream master bundle of the playback
//             sequencer. m_axis_tlast exists only with SPROM_PLAYBACK_TLAST_EN.
//  Revision : 1.0  initial release
// ============================================================================
interface sprom_playback_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
`ifdef SPROM_PLAYBACK_TLAST_EN
    logic              m_axis_tlast;
`endif

    modport master (
        output rom_en,
        output rom_addr,
        input  rom_data,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tdata
`ifdef SPROM_PLAYBACK_TLAST_EN
        , output m_axis_tlast
`endif
    );

    modport slave (
        input  rom_en,
        input  rom_addr,
        output rom_data,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tdata
`ifdef SPROM_PLAYBACK_TLAST_EN
        , input  m_axis_tlast
`endif
    );
endinterface
`default_nettype wire

// File: rtl/sprom_playback_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sprom_playback_ctrl
//  Brief    : Plays ROM window [start, start+length) a programmed number of
//             times as an AXI4-Stream; optional tlast via SPROM_PLAYBACK_TLAST_EN.
//  Revision : 1.0  initial release
// ============================================================================
module sprom_playback_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LOOP_W = 16
) (
    input  wire                  aclk,
    input  wire                  rst_n,
    input  wire [ADDR_W-1:0]     cfg_start_addr,
    input  wire [ADDR_W:0]       cfg_length,
    input  wire [LOOP_W-1:0]     cfg_loops,
    input  wire                  cmd_start,
    input  wire                  cmd_stop,
    output logic                 busy,
    output logic                 done,
    sprom_playback_ctrl_if.master bus
);
    localparam int         c_LEN_W = ADDR_W + 1;
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]        r_state, w_state_next;
    logic [ADDR_W-1:0] r_start;
    logic [ADDR_W:0]   r_len, r_offset;
    logic [LOOP_W-1:0] r_loops_left;
    logic              r_infinite;
    logic              r_inflight;
    logic [DATA_W-1:0] r_buf_data [2];
    logic [1:0]        r_count;
    logic              r_rd_ptr, r_wr_ptr;
`ifdef SPROM_PLAYBACK_TLAST_EN
    logic              r_inflight_last;
    logic              r_buf_last [2];
`endif

    logic w_accept, w_tvalid, w_pop, w_credit, w_issue;
    logic w_pass_end, w_final_read, w_drained;

    assign w_accept     = (r_state == c_IDLE) && cmd_start && !cmd_stop && (cfg_length != '0);
    assign w_tvalid     = (r_count != 2'd0);
    assign w_pop        = w_tvalid && bus.m_axis_tready;
    // A read is issued only if its word is guaranteed a buffer slot next cycle.
    assign w_credit     = (({1'b0, r_count} + 3'(r_inflight) - 3'(w_pop)) < 3'd2);
    assign w_issue      = (r_state == c_RUN) && w_credit;
    assign w_pass_end   = w_issue && (r_offset == (r_len - c_LEN_W'(1)));
    assign w_final_read = w_pass_end && !r_infinite && (r_loops_left == LOOP_W'(1));
    assign w_drained    = (r_count == 2'd0) && !r_inflight;

    assign bus.rom_en        = w_issue;
    assign bus.rom_addr      = r_start + r_offset[ADDR_W-1:0];
    assign bus.m_axis_tvalid = w_tvalid;
    assign bus.m_axis_tdata  = r_buf_data[r_rd_ptr];
`ifdef SPROM_PLAYBACK_TLAST_EN
    assign bus.m_axis_tlast  = r_buf_last[r_rd_ptr];
`endif

    always_ff @(posedge aclk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_accept) w_state_next = c_RUN;
            end
            c_RUN: begin
                busy = 1'b1;
                if (cmd_stop || w_final_read) w_state_next = c_DRAIN;
            end
            c_DRAIN: begin
                busy = 1'b1;
                if (w_drained) begin
                    done         = 1'b1;
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!rst_n) begin
            r_start      <= '0;
            r_len        <= '0;
            r_offset     <= '0;
            r_loops_left <= '0;
            r_infinite   <= 1'b0;
            r_inflight   <= 1'b0;
            r_count      <= 2'd0;
            r_rd_ptr     <= 1'b0;
            r_wr_ptr     <= 1'b0;
            for (int i = 0; i < 2; i++) r_buf_data[i] <= '0;
`ifdef SPROM_PLAYBACK_TLAST_EN
            r_inflight_last <= 1'b0;
            for (int i = 0; i < 2; i++) r_buf_last[i] <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_start      <= cfg_start_addr;
                r_len        <= cfg_length;
                r_offset     <= '0;
                r_loops_left <= cfg_loops;
                r_infinite   <= (cfg_loops == '0);
            end else if (w_issue) begin
                if (w_pass_end) begin
                    r_offset <= '0;
                    if (!r_infinite) r_loops_left <= r_loops_left - LOOP_W'(1);
                end else begin
                    r_offset <= r_offset + c_LEN_W'(1);
                end
            end

            // ROM data is valid exactly one cycle after the read was issued.
            r_inflight <= w_issue;
            if (r_inflight) begin
                r_buf_data[r_wr_ptr] <= bus.rom_data;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + 2'(r_inflight) - 2'(w_pop);
`ifdef SPROM_PLAYBACK_TLAST_EN
            r_inflight_last <= w_pass_end;
            if (r_inflight) r_buf_last[r_wr_ptr] <= r_inflight_last;
`endif
        end
    end
endmodule
`default_nettype wire
